// File: rtl/check_pkg.sv
// Shared types for the retirement lockstep checker.
//   retire_entry_t : one retired instruction record (memory fields present only
//                    when RETIRE_SCOREBOARD_MEMCHK_EN is defined)
//   fault_cause_e  : sticky fault cause encoding
//   state_e        : checker state
//   MASK_*         : bit positions in the field mismatch mask
//   entry_diff     : field-by-field compare of two records, returns the mask
package check_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rd_val;
`ifdef RETIRE_SCOREBOARD_MEMCHK_EN
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [1:0]  mem_size;
        logic [31:0] mem_data;
`endif
    } retire_entry_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISMATCH = 2'd1,
        CAUSE_OVERFLOW = 2'd2,
        CAUSE_PROTO    = 2'd3
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam int MASK_PC  = 0;
    localparam int MASK_RD  = 1;
    localparam int MASK_VAL = 2;
    localparam int MASK_MEM = 3;

    function automatic logic [3:0] entry_diff(input retire_entry_t a, input retire_entry_t b);
        logic [3:0] m;
        m = '0;
        m[MASK_PC] = (a.pc != b.pc);
        m[MASK_RD] = (a.rd != b.rd);
        // x0 writes carry no architectural value
        m[MASK_VAL] = (a.rd != '0) && (b.rd != '0) && (a.rd_val != b.rd_val);
`ifdef RETIRE_SCOREBOARD_MEMCHK_EN
        m[MASK_MEM] = (a.mem_we != b.mem_we) ||
                      (a.mem_we && b.mem_we &&
                       ({a.mem_addr, a.mem_size, a.mem_data} != {b.mem_addr, b.mem_size, b.mem_data}));
`endif
        return m;
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// Multi-write, single-read record buffer.
//   clk, rst   : clock, synchronous active-high reset (drops all entries)
//   wr_cnt_i   : number of entries to write this cycle, taken from wr_data_i[0..]
//   wr_data_i  : write records, element 0 is oldest
//   rd_en_i    : pop the head (caller guarantees non-empty)
//   rd_data_o  : head record
//   occ_o      : occupancy; full/empty are derived from this, not from pointers
// Build option RETIRE_SCOREBOARD_MEMCHK_EN widens the stored record.
module retire_fifo
    import check_pkg::*;
#(
    parameter int  WR_W   = 1,
    parameter int  DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int OCC_W  = $clog2(DEPTH + 1),
    localparam int LCNT_W = $clog2(WR_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LCNT_W-1:0]        wr_cnt_i,
    input  retire_entry_t [WR_W-1:0] wr_data_i,
    input  logic                     rd_en_i,
    output retire_entry_t            rd_data_o,
    output logic [OCC_W-1:0]         occ_o
);

    retire_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_W; i++) begin
            if (LCNT_W'(i) < wr_cnt_i) begin
                mem_q[wptr_q + PTR_W'(i)] <= wr_data_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_q + PTR_W'(wr_cnt_i);
            rptr_q <= rptr_q + PTR_W'(rd_en_i);
            occ_q  <= occ_q + OCC_W'(wr_cnt_i) - OCC_W'(rd_en_i);
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign occ_o     = occ_q;

endmodule

// File: rtl/retire_scoreboard.sv
// Lockstep checker: buffers multi-lane DUT retirements and serial reference
// retirements, compares one head pair per cycle and latches the first fault.
//   clk, rst          : clock, synchronous active-high reset
//   en_i              : checking enable
//   dut_valid_i/entry : DUT retire lanes, lane 0 oldest, mask must be contiguous
//   ref_valid_i/entry : reference record, accepted when ref_ready_o
//   ref_ready_o       : reference buffer not full
//   fault_*           : sticky fault flag, cause, field mask, head pcs
//   cmp_cnt_o         : successful compares (saturating)
//   dut_occ_o         : DUT buffer occupancy
// Build option RETIRE_SCOREBOARD_MEMCHK_EN adds memory-write checking.
//
// state    | meaning
// ST_IDLE  | enable low, buffers held; en_i high acts as the first RUN cycle
// ST_RUN   | pushing, comparing, watchdog counting
// ST_FAULT | fault latched, everything frozen until rst
module retire_scoreboard
    import check_pkg::*;
#(
    parameter int RETIRE_W = 3,
    parameter int DEPTH    = 16,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_i,
    input  logic [RETIRE_W-1:0]            dut_valid_i,
    input  retire_entry_t [RETIRE_W-1:0]   dut_entry_i,
    input  logic                           ref_valid_i,
    input  retire_entry_t                  ref_entry_i,
    output logic                           ref_ready_o,
    output logic                           fault_o,
    output logic [1:0]                     fault_cause_o,
    output logic [3:0]                     fault_mask_o,
    output logic [31:0]                    fault_pc_dut_o,
    output logic [31:0]                    fault_pc_ref_o,
    output logic [CNT_W-1:0]               cmp_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0]     dut_occ_o
);

    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int LCNT_W  = $clog2(RETIRE_W + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    state_e              state_q;
    logic [STALL_W-1:0]  stall_q;
    logic [CNT_W-1:0]    cmp_cnt_q;
    logic                fault_q;
    fault_cause_e        cause_q;
    logic [3:0]          mask_q;
    logic [31:0]         pc_dut_q;
    logic [31:0]         pc_ref_q;

    retire_entry_t       dut_head;
    retire_entry_t       ref_head;
    logic [OCC_W-1:0]    dut_occ;
    logic [OCC_W-1:0]    ref_occ;

    logic [LCNT_W-1:0]   lane_cnt;
    logic [LCNT_W-1:0]   dut_wr_cnt;
    logic                act, go, dut_ne, ref_ne, pop_ok, pop, ref_wr;
    logic                proto, ovf, mism, tmo, any_fault;
    logic [3:0]          diff_mask;
    fault_cause_e        cause_d;
    logic [3:0]          mask_d;

    assign ref_ready_o = (ref_occ != OCC_W'(DEPTH));

    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            lane_cnt = lane_cnt + LCNT_W'(dut_valid_i[i]);
        end
        act       = en_i && (state_q != ST_FAULT);
        dut_ne    = (dut_occ != '0);
        ref_ne    = (ref_occ != '0);
        diff_mask = entry_diff(dut_head, ref_head);
        pop_ok    = dut_ne && ref_ne && (diff_mask == '0);
        // a mask is contiguous from bit 0 exactly when +1 clears every set bit
        proto     = act && ((dut_valid_i & (dut_valid_i + RETIRE_W'(1))) != '0);
        ovf       = act && ((int'(dut_occ) - int'(pop_ok) + int'(lane_cnt)) > DEPTH);
        mism      = act && dut_ne && ref_ne && (diff_mask != '0);
        tmo       = act && (dut_ne != ref_ne) && (stall_q == STALL_W'(TIMEOUT - 1));
        any_fault = proto || ovf || mism || tmo;

        cause_d = CAUSE_NONE;
        mask_d  = '0;
        if (proto) begin
            cause_d = CAUSE_PROTO;
        end else if (ovf) begin
            cause_d = CAUSE_OVERFLOW;
        end else if (mism) begin
            cause_d = CAUSE_MISMATCH;
            mask_d  = diff_mask;
        end else if (tmo) begin
            cause_d = CAUSE_OVERFLOW;
            mask_d  = 4'hF;
        end

        // the faulting cycle itself already freezes the buffers
        go         = act && !any_fault;
        pop        = go && pop_ok;
        dut_wr_cnt = go ? lane_cnt : '0;
        ref_wr     = go && ref_valid_i && ref_ready_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stall_q   <= '0;
            cmp_cnt_q <= '0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            mask_q    <= '0;
            pc_dut_q  <= '0;
            pc_ref_q  <= '0;
        end else begin
            case (state_q)
                ST_FAULT: begin
                end
                default: begin
                    if (any_fault) begin
                        state_q  <= ST_FAULT;
                        fault_q  <= 1'b1;
                        cause_q  <= cause_d;
                        mask_q   <= mask_d;
                        pc_dut_q <= dut_ne ? dut_head.pc : '0;
                        pc_ref_q <= ref_ne ? ref_head.pc : '0;
                    end else begin
                        state_q <= en_i ? ST_RUN : ST_IDLE;
                        if (pop && (cmp_cnt_q != '1)) begin
                            cmp_cnt_q <= cmp_cnt_q + CNT_W'(1);
                        end
                        if (act) begin
                            if (pop || (!dut_ne && !ref_ne)) begin
                                stall_q <= '0;
                            end else if (dut_ne != ref_ne) begin
                                stall_q <= stall_q + STALL_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    retire_fifo #(.WR_W(RETIRE_W), .DEPTH(DEPTH)) u_dut_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_cnt_i  (dut_wr_cnt),
        .wr_data_i (dut_entry_i),
        .rd_en_i   (pop),
        .rd_data_o (dut_head),
        .occ_o     (dut_occ)
    );

    retire_fifo #(.WR_W(1), .DEPTH(DEPTH)) u_ref_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_cnt_i  (ref_wr),
        .wr_data_i (ref_entry_i),
        .rd_en_i   (pop),
        .rd_data_o (ref_head),
        .occ_o     (ref_occ)
    );

    assign fault_o        = fault_q;
    assign fault_cause_o  = cause_q;
    assign fault_mask_o   = mask_q;
    assign fault_pc_dut_o = pc_dut_q;
    assign fault_pc_ref_o = pc_ref_q;
    assign cmp_cnt_o      = cmp_cnt_q;
    assign dut_occ_o      = dut_occ;

endmodule
